// File: rtl/sep_blur_controller.sv
// Separable 5x5 blur controller for one tile row at a time.
// A padded input row is filtered horizontally into a 5-row history. The history
// columns are then filtered vertically into out_data. Each pass handles LANES
// pixels per cycle, so each pass takes N = TILE_W/LANES cycles.
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   flush                   synchronous abort: clears history, returns to IDLE
//   in_valid/in_ready       row handshake; sof and mode qualify row_in
//   sof                     first row of frame (top-edge replicate)
//   mode                    0 bypass, 1 [1,2,1], 2/3 [1,4,6,4,1]
//   row_in                  (TILE_W+4) pixels, pixel k at [k*PIX_W +: PIX_W]
//   out_valid/out_ready     result handshake
//   out_data                TILE_W filtered pixels, same packing
//   busy                    FSM not idle
module sep_blur_controller #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned TILE_W = 16,
  parameter int unsigned LANES  = 2
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        sof,
  input  logic [1:0]                  mode,
  input  logic [(TILE_W+4)*PIX_W-1:0] row_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TILE_W*PIX_W-1:0]     out_data,
  output logic                        busy
);

  localparam int unsigned N    = TILE_W / LANES;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IdxW = (TILE_W > 1) ? $clog2(TILE_W) : 1;

  typedef enum logic [1:0] {StIdle, StHpass, StVpass, StOutput} state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q;
  logic [(TILE_W+4)*PIX_W-1:0]   row_q;
  logic                          sof_q;
  logic [1:0]                    mode_q;
  logic [PIX_W-1:0]              hist_q [5][TILE_W];
  logic [TILE_W*PIX_W-1:0]       out_data_q;

  logic                          accept;
  logic                          last_step;
  logic [IdxW-1:0]               lane_idx [LANES];
  logic [PIX_W-1:0]              h_lane   [LANES];
  logic [PIX_W-1:0]              v_lane   [LANES];

  // Symmetric 5/3-tap kernel; sums are sized so no result can overflow PIX_W.
  function automatic logic [PIX_W-1:0] filt(input logic [1:0]       m,
                                            input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c,
                                            input logic [PIX_W-1:0] d,
                                            input logic [PIX_W-1:0] e);
    logic [PIX_W+3:0] s5;
    logic [PIX_W+1:0] s3;
    s5 = {4'b0, a} + ({4'b0, b} << 2) + ({4'b0, c} << 2) + ({4'b0, c} << 1)
       + ({4'b0, d} << 2) + {4'b0, e} + (PIX_W+4)'(8);
    s3 = {2'b0, b} + ({2'b0, c} << 1) + {2'b0, d} + (PIX_W+2)'(2);
    case (m)
      2'd0:    filt = c;
      2'd1:    filt = s3[PIX_W+1:2];
      default: filt = s5[PIX_W+3:4];
    endcase
  endfunction

  assign accept    = (state_q == StIdle) && in_valid && !flush;
  assign last_step = (cnt_q == CntW'(N - 1));
  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StOutput);
  assign out_data  = out_data_q;

  // Per-lane column index and filter results for the current step.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx[l] = IdxW'(32'(cnt_q) * LANES + l);
      h_lane[l]   = filt(mode_q,
                         row_q[(32'(lane_idx[l]) + 0) * PIX_W +: PIX_W],
                         row_q[(32'(lane_idx[l]) + 1) * PIX_W +: PIX_W],
                         row_q[(32'(lane_idx[l]) + 2) * PIX_W +: PIX_W],
                         row_q[(32'(lane_idx[l]) + 3) * PIX_W +: PIX_W],
                         row_q[(32'(lane_idx[l]) + 4) * PIX_W +: PIX_W]);
      v_lane[l]   = filt(mode_q,
                         hist_q[4][lane_idx[l]],
                         hist_q[3][lane_idx[l]],
                         hist_q[2][lane_idx[l]],
                         hist_q[1][lane_idx[l]],
                         hist_q[0][lane_idx[l]]);
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (in_valid)  state_d = StHpass;
        StHpass:  if (last_step) state_d = StVpass;
        StVpass:  if (last_step) state_d = StOutput;
        StOutput: if (out_ready) state_d = StIdle;
        default:                 state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q      <= '0;
      row_q      <= '0;
      sof_q      <= 1'b0;
      mode_q     <= 2'd0;
      out_data_q <= '0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < int'(TILE_W); j++) begin
          hist_q[i][j] <= '0;
        end
      end
    end else if (flush) begin
      // out_data deliberately keeps its last value.
      cnt_q <= '0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < int'(TILE_W); j++) begin
          hist_q[i][j] <= '0;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            row_q  <= row_in;
            sof_q  <= sof;
            mode_q <= mode;
            cnt_q  <= '0;
            for (int i = 4; i > 0; i--) begin
              hist_q[i] <= hist_q[i-1];
            end
          end
        end
        StHpass: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            hist_q[0][lane_idx[l]] <= h_lane[l];
            // First row of a frame: replicate upward so the top edge is padded.
            if (sof_q) begin
              for (int i = 1; i < 5; i++) begin
                hist_q[i][lane_idx[l]] <= h_lane[l];
              end
            end
          end
          cnt_q <= last_step ? '0 : cnt_q + 1'b1;
        end
        StVpass: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            out_data_q[32'(lane_idx[l]) * PIX_W +: PIX_W] <= v_lane[l];
          end
          cnt_q <= last_step ? '0 : cnt_q + 1'b1;
        end
        StOutput: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sep_blur_controller.sv
module tb_sep_blur_controller;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned TILE_W = 16;
  localparam int unsigned LANES  = 2;
  localparam int unsigned N      = TILE_W / LANES;
  localparam int unsigned IN_W   = (TILE_W + 4) * PIX_W;
  localparam int unsigned OUT_W  = TILE_W * PIX_W;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             sof;
  logic [1:0]       mode;
  logic [IN_W-1:0]  row_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int mh [5][TILE_W];
  logic [OUT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  sep_blur_controller #(
    .PIX_W (PIX_W),
    .TILE_W(TILE_W),
    .LANES (LANES)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sof      (sof),
    .mode     (mode),
    .row_in   (row_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [OUT_W-1:0] obs,
                       input logic [OUT_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tap(input int m, input int a, input int b, input int c,
                             input int d, input int e);
    if (m == 0) return c;
    if (m == 1) return (b + 2 * c + d + 2) / 4;
    return (a + 4 * b + 6 * c + 4 * d + e + 8) / 16;
  endfunction

  function automatic int px(input logic [IN_W-1:0] r, input int k);
    return int'(r[k * PIX_W +: PIX_W]);
  endfunction

  function automatic logic [IN_W-1:0] row_const(input int v);
    logic [IN_W-1:0] r;
    for (int k = 0; k < int'(TILE_W) + 4; k++) r[k * PIX_W +: PIX_W] = PIX_W'(v);
    return r;
  endfunction

  function automatic logic [IN_W-1:0] row_one(input int k, input int v);
    logic [IN_W-1:0] r;
    r = '0;
    r[k * PIX_W +: PIX_W] = PIX_W'(v);
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] out_const(input int v);
    logic [OUT_W-1:0] r;
    for (int k = 0; k < int'(TILE_W); k++) r[k * PIX_W +: PIX_W] = PIX_W'(v);
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] out_one(input int k, input int v);
    logic [OUT_W-1:0] r;
    r = '0;
    r[k * PIX_W +: PIX_W] = PIX_W'(v);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < int'(TILE_W); j++) mh[i][j] = 0;
  endtask

  // Reference: horizontal pass into history, then vertical pass per column.
  task automatic model_row(input logic [IN_W-1:0] r, input logic s, input logic [1:0] m);
    logic [OUT_W-1:0] res;
    int h;
    for (int i = 4; i > 0; i--)
      for (int j = 0; j < int'(TILE_W); j++) mh[i][j] = mh[i-1][j];
    for (int j = 0; j < int'(TILE_W); j++) begin
      h = tap(int'(m), px(r, j), px(r, j + 1), px(r, j + 2), px(r, j + 3), px(r, j + 4));
      mh[0][j] = h;
      if (s) for (int i = 1; i < 5; i++) mh[i][j] = h;
    end
    for (int j = 0; j < int'(TILE_W); j++)
      res[j * PIX_W +: PIX_W] = PIX_W'(tap(int'(m), mh[4][j], mh[3][j], mh[2][j],
                                           mh[1][j], mh[0][j]));
    exp_q.push_back(res);
  endtask

  // Send one row, wait for its result, optionally stall the consumer, compare.
  task automatic run_row(input logic [IN_W-1:0] r, input logic s, input logic [1:0] m,
                         input int hold, output logic [OUT_W-1:0] got);
    int edges;
    logic [OUT_W-1:0] snap;
    logic [OUT_W-1:0] expv;
    check("in_ready_before_accept", OUT_W'(in_ready), OUT_W'(1));
    row_in    = r;
    sof       = s;
    mode      = m;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    model_row(r, s, m);
    if (hold > 0) begin
      // Junk request held high while busy must be ignored.
      row_in = ~r;
      sof    = ~s;
      mode   = ~m;
    end else begin
      in_valid = 1'b0;
    end
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("out_valid_latency", OUT_W'(edges), OUT_W'(2 * N));
    snap = out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_data", out_data, snap);
      check("hold_in_ready", OUT_W'(in_ready), OUT_W'(0));
      check("hold_out_valid", OUT_W'(out_valid), OUT_W'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", OUT_W'(out_valid), OUT_W'(0));
    check("in_ready_after", OUT_W'(in_ready), OUT_W'(1));
    check("scoreboard_depth", OUT_W'(exp_q.size()), OUT_W'(1));
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("row_data", snap, expv);
    got = snap;
  endtask

  initial begin
    logic [OUT_W-1:0] got;
    logic [IN_W-1:0]  rr;

    n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; sof = 1'b0; mode = 2'd0;
    row_in = '0; out_ready = 1'b0;
    model_clear();
    #12;
    check("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    check("rst_busy", OUT_W'(busy), OUT_W'(0));
    check("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check("rst_out_data", out_data, '0);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    // Flat field stays flat.
    run_row(row_const(100), 1'b1, 2'd2, 0, got);
    check("flat100", got, out_const(100));

    // Impulse through 5-tap with top replicate.
    run_row(row_one(10, 160), 1'b1, 2'd2, 0, got);
    check("impulse5", got, out_one(6, 10) | out_one(7, 40) | out_one(8, 60)
                           | out_one(9, 40) | out_one(10, 10));

    // 3-tap rounding, then a mode change on the following row.
    run_row(row_one(9, 1), 1'b1, 2'd1, 0, got);
    check("round3", got, out_one(7, 1));
    run_row(row_one(9, 16), 1'b0, 2'd2, 0, got);

    // Vertical path: zero row above a flat 160 row.
    run_row(row_const(0), 1'b1, 2'd2, 0, got);
    run_row(row_const(160), 1'b0, 2'd2, 0, got);
    check("vert5", got, out_const(10));
    run_row(row_const(0), 1'b1, 2'd0, 0, got);
    run_row(row_const(160), 1'b0, 2'd0, 0, got);
    check("vert_bypass", got, out_const(0));

    // Backpressure and random rows across all modes.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < int'(TILE_W) + 4; k++)
        rr[k * PIX_W +: PIX_W] = PIX_W'($urandom_range(255, 0));
      run_row(rr, (t == 0), 2'(t), (t == 1) ? 5 : (t % 3), got);
    end

    // Flush at HPASS step 3, including a flushed request in IDLE.
    row_in = row_const(50); sof = 1'b1; mode = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_flush_busy", OUT_W'(busy), OUT_W'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_in_ready", OUT_W'(in_ready), OUT_W'(1));
    check("flush_out_valid", OUT_W'(out_valid), OUT_W'(0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_blocks_accept", OUT_W'(busy), OUT_W'(0));
    model_clear();
    run_row(row_const(100), 1'b1, 2'd2, 0, got);
    check("after_flush", got, out_const(100));

    // Reset mid-VPASS.
    row_in = row_const(77); sof = 1'b1; mode = 2'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N + 3) begin @(posedge clk); #1; end
    n_rst = 1'b0;
    #1;
    check("midrst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    check("midrst_busy", OUT_W'(busy), OUT_W'(0));
    check("midrst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check("midrst_out_data", out_data, '0);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    model_clear();
    run_row(row_const(100), 1'b1, 2'd2, 0, got);
    check("after_reset", got, out_const(100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sep_blur_controller.md
SEP_BLUR_CONTROLLER -- requirements
Module: sep_blur_controller

Interface
REQ-001 The block SHALL expose parameter PIX_W, default 8, bits per pixel.
REQ-002 The block SHALL expose parameter TILE_W, default 16, output pixels per row; the input row SHALL carry TILE_W+4 pixels, 2 halo pixels each side.
REQ-003 The block SHALL expose parameter LANES, default 2, pixels filtered per cycle per pass; TILE_W SHALL be a multiple of LANES, and N = TILE_W/LANES below.
REQ-004 The block SHALL expose ports as follows (one clock; reset is asynchronous and active-low):
 clk  input  1  clock
 n_rst  input  1  async active-low reset
 flush  input  1  sync abort: clears history, returns FSM to IDLE
 in_valid  input  1  row_in/sof/mode valid
 in_ready  output  1  block accepts a row
 sof  input  1  row is first of frame
 mode  input  2  0 bypass, 1 3-tap [1,2,1], 2 5-tap [1,4,6,4,1], 3 reserved (treated as 2)
 row_in  input  (TILE_W+4)*PIX_W  padded input row, pixel k at bits [k*PIX_W +: PIX_W]
 out_valid  output  1  out_data valid
 out_ready  input  1  consumer accepts out_data
 out_data  output  TILE_W*PIX_W  filtered row, same packing
 busy  output  1  state != IDLE

Function
REQ-005 The FSM SHALL have states IDLE, HPASS, VPASS and OUTPUT; in_ready = (state==IDLE) and busy = (state!=IDLE).
REQ-006 On accept (in_valid & in_ready), row_in, sof and mode SHALL be latched, the 5-row history SHALL shift (hist[4:1] <= hist[3:0]), and the state SHALL go to HPASS.
REQ-007 HPASS SHALL last exactly N cycles; in step s, lanes j = s*LANES .. s*LANES+LANES-1 SHALL compute h[j] from latched pixels j..j+4 and write it to hist[0][j].
REQ-008 When the latched sof = 1, each HPASS result SHALL also be written to hist[1..4][j] (top-edge replicate).
REQ-009 VPASS SHALL last exactly N cycles; in step s, those lanes SHALL compute v[j] from hist[0..4][j] and write out_data[j].
REQ-010 After VPASS the state SHALL be OUTPUT with out_valid = 1; out_valid SHALL rise exactly 2N clock edges after the accept edge (16 at defaults).
REQ-011 In OUTPUT, out_data SHALL be held stable until out_ready = 1; on that edge the state SHALL go to IDLE and out_valid SHALL drop.
REQ-012 The 5-tap result SHALL be (1*a+4*b+6*c+4*d+1*e + 8) >> 4, computed in PIX_W+4 bits.
REQ-013 The 3-tap result SHALL use the centre three taps: (b+2*c+d + 2) >> 2, computed in PIX_W+2 bits.
REQ-014 Bypass SHALL pass the centre tap c unchanged.
REQ-015 Horizontal c is padded pixel j+2; vertical c is hist[2][j], with hist[0] the newest row.
REQ-016 Horizontal results SHALL be rounded to PIX_W before storage; no result SHALL exceed 2^PIX_W-1, and no saturation logic is required.
REQ-017 The latched mode SHALL apply to both passes of that row; a mode change between rows SHALL take effect on the next accepted row only.
REQ-018 in_valid while busy SHALL be ignored, with no latch and no state change.
REQ-019 flush SHALL take priority over all other activity in every state: the next state SHALL be IDLE, hist SHALL be zeroed, and out_valid SHALL be 0; out_data SHALL retain its value.
REQ-020 flush together with in_valid in IDLE SHALL not accept the row.

Reset
REQ-021 On n_rst low, the block SHALL asynchronously set state=IDLE, hist=0, out_data=0, out_valid=0, in_ready=1 and busy=0, and SHALL abandon any row in flight.
REQ-022 After n_rst release, the first accepted row SHALL behave as after flush.

Verification (defaults PIX_W=8, TILE_W=16, LANES=2)
REQ-023 Row of all 100, sof=1, mode=2, out_ready=1 -> out_valid after 16 edges, all 16 outputs = 100, then in_ready=1 the following cycle.
REQ-024 sof=1, mode=2, all zero except padded pixel 10 = 160 -> out[6..10] = 10,40,60,40,10, all others 0.
REQ-025 Mode-1 rounding: sof=1 row all zero except padded pixel 9 = 1 -> out[7] = 1, all others 0; a second row with mode=2 and all zero except pixel 9 = 16, no sof -> mode 2 applied to the second row.
REQ-026 Vertical path: sof row of zeros, then a non-sof row of all 160, mode=2 -> outputs all 10; bypass (mode=0) on the same sequence -> outputs all 0.
REQ-027 Backpressure: out_ready low for 5 cycles in OUTPUT -> out_data stable, in_ready=0 and in_valid ignored throughout; out_ready high -> IDLE next edge.
REQ-028 flush at HPASS step 3, and separately n_rst low mid-VPASS -> IDLE, out_valid=0, in_ready=1; the next sof row of 100 -> outputs all 100.
